// File: rtl/apb_master_bridge.sv
// APB3 master bridge: valid/ready command in, SETUP/ACCESS transfer to one of two
// slaves (UART or GPIO), registered response out with a bounded wait-state timeout.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_BIT = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] padd,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  output logic [3:0]        pstrb,
  output logic              penable,
  output logic              psel_uart,
  output logic              psel_gpio,
  input  logic              pready_uart,
  input  logic              pready_gpio,
  input  logic              pslverr_uart,
  input  logic              pslverr_gpio,
  input  logic [DATA_W-1:0] prdata_uart,
  input  logic [DATA_W-1:0] prdata_gpio
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t              state_q, state_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   padd_q, padd_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [3:0]          pstrb_q, pstrb_d;
  logic                penable_q, penable_d;
  logic                psel_uart_q, psel_uart_d;
  logic                psel_gpio_q, psel_gpio_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pready_sel;
  logic                pslverr_sel;
  logic [DATA_W-1:0]   prdata_sel;

  always_comb begin
    // The unselected slave's inputs never reach the response path.
    pready_sel  = psel_gpio_q ? pready_gpio  : pready_uart;
    pslverr_sel = psel_gpio_q ? pslverr_gpio : pslverr_uart;
    prdata_sel  = psel_gpio_q ? prdata_gpio  : prdata_uart;

    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    padd_d        = padd_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    penable_d     = penable_q;
    psel_uart_d   = psel_uart_q;
    psel_gpio_d   = psel_gpio_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d     = SETUP;
          cmd_ready_d = 1'b0;
          padd_d      = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_wdata;
          pstrb_d     = cmd_write ? cmd_strb : 4'b0000;
          psel_gpio_d = cmd_addr[SEL_BIT];
          psel_uart_d = ~cmd_addr[SEL_BIT];
          penable_d   = 1'b0;
          cnt_d       = '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // pready is checked first so it wins over a same-cycle timeout.
        if (pready_sel) begin
          state_d       = RESP;
          psel_uart_d   = 1'b0;
          psel_gpio_d   = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite_q ? '0 : prdata_sel;
          rsp_err_d     = pslverr_sel;
          rsp_timeout_d = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d       = RESP;
          psel_uart_d   = 1'b0;
          psel_gpio_d   = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          cnt_d         = cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b1;
      padd_q        <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= 4'b0000;
      penable_q     <= 1'b0;
      psel_uart_q   <= 1'b0;
      psel_gpio_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      padd_q        <= padd_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      penable_q     <= penable_d;
      psel_uart_q   <= psel_uart_d;
      psel_gpio_q   <= psel_gpio_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign padd        = padd_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;
  assign penable     = penable_q;
  assign psel_uart   = psel_uart_q;
  assign psel_gpio   = psel_gpio_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed commands against a transaction-timeline model
// plus a simple wait-state slave, with a per-cycle output compare.
module tb_apb_master_bridge;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, padd, pwdata;
  logic        pwrite, penable, psel_uart, psel_gpio;
  logic [3:0]  pstrb;
  logic        pready_uart, pready_gpio, pslverr_uart, pslverr_gpio;
  logic [31:0] prdata_uart, prdata_gpio;

  int checks = 0;
  int errors = 0;

  apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .SEL_BIT(12), .TIMEOUT(TO)) dut (
    .pclk(pclk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .padd(padd), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb), .penable(penable),
    .psel_uart(psel_uart), .psel_gpio(psel_gpio),
    .pready_uart(pready_uart), .pready_gpio(pready_gpio),
    .pslverr_uart(pslverr_uart), .pslverr_gpio(pslverr_gpio),
    .prdata_uart(prdata_uart), .prdata_gpio(prdata_gpio)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: pready after tb_wait wait states (tb_wait<0 means never); the
  // unselected slave drives hostile values that must be ignored.
  int          tb_wait = 0;
  logic        tb_err = 1'b0;
  logic [31:0] tb_rdata = '0;
  int          acc_cnt;
  logic        ready_now;

  always @(posedge pclk or posedge rst) begin
    if (rst) acc_cnt <= 0;
    else     acc_cnt <= ((psel_uart | psel_gpio) & penable) ? acc_cnt + 1 : 0;
  end

  assign ready_now    = (psel_uart | psel_gpio) & penable & (tb_wait >= 0) & (acc_cnt == tb_wait);
  assign pready_uart  = psel_uart ? ready_now : 1'b1;
  assign pready_gpio  = psel_gpio ? ready_now : 1'b1;
  assign pslverr_uart = psel_uart ? tb_err : 1'b1;
  assign pslverr_gpio = psel_gpio ? tb_err : 1'b1;
  assign prdata_uart  = psel_uart ? tb_rdata : 32'hDEAD_BEEF;
  assign prdata_gpio  = psel_gpio ? tb_rdata : 32'hDEAD_BEEF;

  // Model: a transfer is a timeline of k cycles after acceptance:
  // k=1 setup, k=2..n+1 access (n = access cycles), k>=n+2 response.
  bit          m_busy;
  int          m_k, m_n;
  logic        m_gpio, m_write, m_to, m_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;

  always @(posedge pclk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
    end else if (!m_busy) begin
      if (cmd_valid) begin
        automatic logic to = (tb_wait < 0) || (tb_wait >= TO);
        m_busy  <= 1'b1;
        m_k     <= 1;
        m_n     <= to ? TO : tb_wait + 1;
        m_to    <= to;
        m_gpio  <= cmd_addr[12];
        m_write <= cmd_write;
        m_addr  <= cmd_addr;
        m_wdata <= cmd_wdata;
        m_strb  <= cmd_write ? cmd_strb : 4'h0;
        m_rdata <= (cmd_write || to) ? 32'h0 : tb_rdata;
        m_err   <= to | tb_err;
      end
    end else if (m_k >= m_n + 2 && rsp_ready) begin
      m_busy <= 1'b0;
    end else begin
      m_k <= m_k + 1;
    end
  end

  always @(negedge pclk) begin
    automatic logic sel_e = m_busy && m_k >= 1 && m_k <= m_n + 1;
    automatic logic en_e  = m_busy && m_k >= 2 && m_k <= m_n + 1;
    automatic logic rv_e  = m_busy && m_k >= m_n + 2;
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
    chk("psel_uart", 32'(psel_uart), 32'(sel_e && !m_gpio));
    chk("psel_gpio", 32'(psel_gpio), 32'(sel_e && m_gpio));
    chk("penable", 32'(penable), 32'(en_e));
    chk("rsp_valid", 32'(rsp_valid), 32'(rv_e));
    if (sel_e) begin
      chk("padd", padd, m_addr);
      chk("pwrite", 32'(pwrite), 32'(m_write));
      chk("pwdata", pwdata, m_wdata);
      chk("pstrb", 32'(pstrb), 32'(m_strb));
    end
    if (rv_e) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
    end
  end

  task automatic do_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input int w, input logic err,
                        input logic [31:0] rdata, input int hold,
                        output int lat, output int pc, output logic [31:0] rd,
                        output logic re, output logic rt);
    @(negedge pclk);
    tb_wait = w; tb_err = err; tb_rdata = rdata;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    rsp_ready = 1'b0;
    @(negedge pclk);
    cmd_valid = 1'b0;
    lat = 1;
    pc = (psel_uart | psel_gpio) ? 1 : 0;
    while (!rsp_valid && lat < 40) begin
      @(negedge pclk);
      lat++;
      if (psel_uart | psel_gpio) pc++;
    end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_wait actual=no_response required=response within 40 cycles");
    end
    rd = rsp_rdata; re = rsp_err; rt = rsp_timeout;
    repeat (hold) begin
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_1FFC; cmd_wdata = 32'h0BAD_0BAD;
      @(negedge pclk);
    end
    if (hold > 0) chk("hold_rdata", rsp_rdata, rd);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge pclk);
    rsp_ready = 1'b0;
  endtask

  int          lat, pc;
  logic [31:0] rd;
  logic        re, rt;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0;
    #12;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("rst_psel", 32'({psel_uart, psel_gpio, penable}), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_padd", padd, 32'h0);
    @(negedge pclk);
    rst = 1'b0;

    // UART write, ready on first access cycle
    do_cmd(1'b1, 32'h0000_0004, 32'h0000_00A5, 4'h1, 0, 1'b0, 32'h1111_1111, 0, lat, pc, rd, re, rt);
    chk("wr_uart_lat", 32'(lat), 32'd3);
    chk("wr_uart_psel_cycles", 32'(pc), 32'd2);
    chk("wr_uart_rdata", rd, 32'h0);
    chk("wr_uart_err", 32'({re, rt}), 32'h0);

    // GPIO read with two wait states
    do_cmd(1'b0, 32'h0000_1000, 32'h0000_0055, 4'hF, 2, 1'b0, 32'h1234_5678, 0, lat, pc, rd, re, rt);
    chk("rd_gpio_lat", 32'(lat), 32'd5);
    chk("rd_gpio_psel_cycles", 32'(pc), 32'd4);
    chk("rd_gpio_rdata", rd, 32'h1234_5678);
    chk("rd_gpio_err", 32'({re, rt}), 32'h0);

    // Slave error on UART write
    do_cmd(1'b1, 32'h0000_0008, 32'h0000_0001, 4'h3, 0, 1'b1, 32'h0, 0, lat, pc, rd, re, rt);
    chk("slverr_flags", 32'({re, rt}), 32'h2);

    // Timeout on GPIO read, slave never ready
    do_cmd(1'b0, 32'h0000_1010, 32'h0, 4'h0, -1, 1'b0, 32'h0000_CAFE, 0, lat, pc, rd, re, rt);
    chk("timeout_psel_cycles", 32'(pc), 32'd17);
    chk("timeout_lat", 32'(lat), 32'd18);
    chk("timeout_rdata", rd, 32'h0);
    chk("timeout_flags", 32'({re, rt}), 32'h3);

    // pready on the last allowed access cycle beats the timeout
    do_cmd(1'b0, 32'h0000_1020, 32'h0, 4'h0, TO - 1, 1'b0, 32'h0BEE_F00D, 0, lat, pc, rd, re, rt);
    chk("edge_psel_cycles", 32'(pc), 32'd17);
    chk("edge_rdata", rd, 32'h0BEE_F00D);
    chk("edge_flags", 32'({re, rt}), 32'h0);

    // Response backpressure for 5 cycles with a stray command pending
    do_cmd(1'b0, 32'h0000_0010, 32'h0, 4'h0, 1, 1'b0, 32'hA5A5_5A5A, 5, lat, pc, rd, re, rt);
    chk("bp_lat", 32'(lat), 32'd4);
    chk("bp_rdata", rd, 32'hA5A5_5A5A);

    // Reset asserted in the middle of an ACCESS phase
    @(negedge pclk);
    tb_wait = -1; tb_err = 1'b0; tb_rdata = 32'h7777_7777;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_1004; cmd_wdata = 32'hFFFF_FFFF; cmd_strb = 4'hF;
    @(negedge pclk);
    cmd_valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    chk("pre_rst_penable", 32'(penable), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("mid_rst_outputs", 32'({psel_uart, psel_gpio, penable, rsp_valid, pwrite, rsp_err, rsp_timeout}), 32'h0);
    chk("mid_rst_padd", padd, 32'h0);
    chk("mid_rst_pwdata", pwdata, 32'h0);
    chk("mid_rst_pstrb", 32'(pstrb), 32'h0);
    @(negedge pclk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);
    end

    do_cmd(1'b0, 32'h0000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0000_3C3C, 0, lat, pc, rd, re, rt);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_rdata", rd, 32'h0000_3C3C);

    repeat (2) @(negedge pclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
APB3 master that sits directly upstream of the UART and GPIO APB slaves. It converts a simple valid/ready command interface from the system controller into APB SETUP/ACCESS transfers. It decodes the address to one of two peripheral selects and muxes the read data and response back. A bounded wait-state timeout prevents a hung slave from stalling the controller.

Parameters:
ADDR_W, 32, APB address width
DATA_W, 32, APB data width
SEL_BIT, 12, address bit selecting the slave: 0 = UART, 1 = GPIO
TIMEOUT, 16, maximum ACCESS-phase cycles waiting for pready before aborting; must be >= 1

Ports:
pclk  in  1  APB clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  bridge can accept a command (IDLE only)
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
cmd_strb  in  4  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  controller accepts response
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  slave pslverr or timeout
rsp_timeout  out  1  transfer aborted by timeout
padd  out  ADDR_W  APB address
pwrite  out  1  APB direction
pwdata  out  DATA_W  APB write data
pstrb  out  4  APB strobes (0 on reads)
penable  out  1  APB enable
psel_uart  out  1  UART slave select
psel_gpio  out  1  GPIO slave select
pready_uart, pready_gpio  in  1 each  slave ready
pslverr_uart, pslverr_gpio  in  1 each  slave error
prdata_uart, prdata_gpio  in  DATA_W each  slave read data

Behaviour:
- Reset (async, immediate): state=IDLE. All outputs 0 except cmd_ready=1. Timeout counter 0. Applies mid-transfer as well; the in-flight transfer is dropped with no response.
- FSM states IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: cmd_ready=1. On cmd_valid, latch addr/write/wdata/strb; on reads latched strb=0. Go to SETUP next cycle, with cmd_ready=0 in SETUP.
- SETUP (exactly 1 cycle): selected psel=1 (psel_gpio when cmd_addr[SEL_BIT]=1, else psel_uart), penable=0. padd/pwrite/pwdata/pstrb carry latched values. Go to ACCESS.
- ACCESS: psel held, penable=1. padd/pwrite/pwdata/pstrb stay stable. Sample the selected slave's pready each cycle; the unselected slave's inputs are ignored.
  - pready=1: capture rsp_rdata = selected prdata (reads only, else 0) and rsp_err = selected pslverr; rsp_timeout=0. Drop psel/penable next cycle and go to RESP.
  - Counter increments each ACCESS cycle with pready=0. When it reaches TIMEOUT: rsp_err=1, rsp_timeout=1, rsp_rdata=0, drop psel/penable, go to RESP.
  - pready and the timeout in the same cycle: pready wins.
- RESP: rsp_valid=1, holding data/flags stable until rsp_ready=1. In that cycle, go to IDLE with rsp_valid=0 next cycle and counter cleared.
- Minimum latency: cmd accept to rsp_valid = 3 cycles (SETUP, ACCESS with pready=1, RESP).
- Back-to-back: a new command is accepted only in IDLE, so at least one idle cycle separates APB transfers.
- At most one psel is high at any time. penable=1 only while a psel is 1.

Test Plan:
- Write to UART: cmd addr=0x0000_0004, wdata=0x0000_00A5, strb=0x1, pready_uart asserted on first ACCESS cycle -> psel_uart=1 for 2 cycles, penable only in the 2nd, pwdata=0xA5; rsp_valid 3 cycles after accept with rsp_err=0.
- Read from GPIO with 2 wait states: addr=0x0000_1000, prdata_gpio=0x1234_5678, pready_gpio high on 3rd ACCESS cycle -> psel_gpio only, pstrb=0, rsp_rdata=0x1234_5678, rsp_err=0.
- Slave error: UART write with pslverr_uart=1 alongside pready_uart -> rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, pready_gpio held 0 -> psel_gpio/penable drop after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Response backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and data stable, cmd_ready=0, new cmd_valid ignored until after the handshake.
- Reset during ACCESS -> outputs 0 immediately, cmd_ready=1, no rsp_valid; the next command completes normally.
